prog_loader: RTL and testbench

PROG_LOADER -- requirements
Module: prog_loader

---
 rtl/prog_loader.sv | 147 ++++++++++++++
 tb/tb_prog_loader.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/prog_loader.sv
// prog_loader: receives a framed program image over a byte stream and writes
// it into program memory, holding the core in reset until a good load ends.
//
// Frame: SYNC(0xA5) COUNT {HI LO}*COUNT CSUM, CSUM = mod-256 sum of COUNT,
// every HI and every LO byte.
//
// Ports
//   clk, rst            clock and synchronous active-high reset
//   in_data, in_valid   incoming byte stream
//   in_ready            byte accepted when in_valid && in_ready
//   pm_we/addr/wdata    program-memory write port (one strobe per instruction)
//   core_rst            core reset, released only after a good load
//   done                load complete, core running
//   err                 last frame rejected
module prog_loader #(
  parameter int unsigned ADDR_W  = 8,
  parameter int unsigned INSTR_W = 12,
  parameter int unsigned TIMEOUT = 1000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [7:0]         in_data,
  input  logic               in_valid,
  output logic               in_ready,
  output logic               pm_we,
  output logic [ADDR_W-1:0]  pm_addr,
  output logic [INSTR_W-1:0] pm_wdata,
  output logic               core_rst,
  output logic               done,
  output logic               err
);

  // Count width must hold both any COUNT byte and 2^ADDR_W.
  localparam int unsigned CW = (ADDR_W + 1 > 9) ? ADDR_W + 1 : 9;
  localparam int unsigned TW = $clog2(TIMEOUT + 1);
  localparam int unsigned HW = INSTR_W - 8;
  localparam logic [7:0]    SYNC  = 8'hA5;
  localparam logic [CW-1:0] MAX_N = CW'({1'b1, {ADDR_W{1'b0}}});

  typedef enum logic [2:0] {
    WAIT_SYNC, GET_COUNT, GET_HI, GET_LO, GET_CSUM, RUN, ERROR
  } state_t;

  state_t             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [ADDR_W-1:0]  idx_q, idx_d;
  logic [7:0]         sum_q, sum_d;
  logic [HW-1:0]      hi_q, hi_d;
  logic [TW-1:0]      idle_q, idle_d;
  logic               in_ready_d, pm_we_d, core_rst_d, done_d, err_d;
  logic [ADDR_W-1:0]  pm_addr_d;
  logic [INSTR_W-1:0] pm_wdata_d;
  logic               xfer, in_frame;

  // Next-state, datapath and registered-output decode.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    sum_d      = sum_q;
    hi_d       = hi_q;
    idle_d     = '0;
    pm_we_d    = 1'b0;
    pm_addr_d  = pm_addr;
    pm_wdata_d = pm_wdata;
    xfer       = in_valid && in_ready;
    in_frame   = (state_q == GET_COUNT) || (state_q == GET_HI) ||
                 (state_q == GET_LO)    || (state_q == GET_CSUM);

    case (state_q)
      WAIT_SYNC: if (xfer && in_data == SYNC) state_d = GET_COUNT;
      GET_COUNT: if (xfer) begin
        if (in_data == 8'd0 || CW'(in_data) > MAX_N) begin
          state_d = ERROR;
        end else begin
          cnt_d   = CW'(in_data);
          sum_d   = in_data;
          idx_d   = '0;
          state_d = GET_HI;
        end
      end
      GET_HI: if (xfer) begin
        hi_d    = in_data[HW-1:0];
        sum_d   = sum_q + in_data;
        state_d = GET_LO;
      end
      GET_LO: if (xfer) begin
        pm_we_d    = 1'b1;
        pm_addr_d  = idx_q;
        pm_wdata_d = {hi_q, in_data};
        sum_d      = sum_q + in_data;
        idx_d      = idx_q + ADDR_W'(1);
        cnt_d      = cnt_q - CW'(1);
        state_d    = (cnt_q == CW'(1)) ? GET_CSUM : GET_HI;
      end
      GET_CSUM: if (xfer) state_d = (in_data == sum_q) ? RUN : ERROR;
      RUN:      state_d = RUN;
      ERROR:    if (xfer && in_data == SYNC) state_d = GET_COUNT;
      default:  state_d = WAIT_SYNC;
    endcase

    // Inter-byte watchdog while a frame is open.
    if (in_frame && !xfer) begin
      if (idle_q == TW'(TIMEOUT - 1)) state_d = ERROR;
      else                            idle_d  = idle_q + TW'(1);
    end

    in_ready_d = (state_d != RUN);
    core_rst_d = (state_d != RUN);
    done_d     = (state_d == RUN);
    err_d      = (state_d == ERROR);
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= WAIT_SYNC;
      cnt_q    <= '0;
      idx_q    <= '0;
      sum_q    <= '0;
      hi_q     <= '0;
      idle_q   <= '0;
      in_ready <= 1'b1;
      pm_we    <= 1'b0;
      pm_addr  <= '0;
      pm_wdata <= '0;
      core_rst <= 1'b1;
      done     <= 1'b0;
      err      <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      sum_q    <= sum_d;
      hi_q     <= hi_d;
      idle_q   <= idle_d;
      in_ready <= in_ready_d;
      pm_we    <= pm_we_d;
      pm_addr  <= pm_addr_d;
      pm_wdata <= pm_wdata_d;
      core_rst <= core_rst_d;
      done     <= done_d;
      err      <= err_d;
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
// Testbench for prog_loader: directed frames; expected memory writes are
// queued by the stimulus and checked by an independent write monitor.
module tb_prog_loader;
  localparam int unsigned ADDR_W  = 2;
  localparam int unsigned INSTR_W = 12;
  localparam int unsigned TIMEOUT = 16;

  logic               clk = 1'b0;
  logic               rst;
  logic [7:0]         in_data;
  logic               in_valid;
  logic               in_ready;
  logic               pm_we;
  logic [ADDR_W-1:0]  pm_addr;
  logic [INSTR_W-1:0] pm_wdata;
  logic               core_rst;
  logic               done;
  logic               err;

  int passed = 0;
  int total  = 0;
  logic [ADDR_W+INSTR_W-1:0] exp_q[$];

  prog_loader #(.ADDR_W(ADDR_W), .INSTR_W(INSTR_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .pm_we(pm_we), .pm_addr(pm_addr),
    .pm_wdata(pm_wdata), .core_rst(core_rst), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int req);
    total++;
    if (act == req) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
  endtask

  task automatic expect_write(input int addr, input int data);
    exp_q.push_back({ADDR_W'(addr), INSTR_W'(data)});
  endtask

  // Offer one byte, starting posedge+1; returns posedge+1 after transfer.
  task automatic send(input logic [7:0] b);
    int n = 0;
    in_data  = b;
    in_valid = 1'b1;
    while (!in_ready && n < 50) begin
      @(posedge clk); #1; n++;
    end
    if (!in_ready) check("send_ready_timeout", 0, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_in_ready"}, int'(in_ready), 1);
    check({tag, "_core_rst"}, int'(core_rst), 1);
    check({tag, "_done"},     int'(done), 0);
    check({tag, "_err"},      int'(err), 0);
    check({tag, "_pm_we"},    int'(pm_we), 0);
    check({tag, "_pm_addr"},  int'(pm_addr), 0);
    check({tag, "_pm_wdata"}, int'(pm_wdata), 0);
  endtask

  // Write monitor: every strobe must match the next queued expectation.
  initial begin
    forever begin
      @(negedge clk);
      if (pm_we) begin
        if (exp_q.size() == 0) begin
          check("unexpected_pm_we_addr", int'(pm_addr), -1);
        end else begin
          logic [ADDR_W+INSTR_W-1:0] e;
          e = exp_q.pop_front();
          check("pm_addr",  int'(pm_addr),  int'(e[ADDR_W+INSTR_W-1:INSTR_W]));
          check("pm_wdata", int'(pm_wdata), int'(e[INSTR_W-1:0]));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = 8'h00;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    check_reset_vals("reset");

    // Good load.
    expect_write(0, 'h123);
    expect_write(1, 'hFFF);
    send(8'hA5); send(8'h02); send(8'h01); send(8'h23);
    send(8'h0F); send(8'hFF);
    check("good_core_rst_before_csum", int'(core_rst), 1);
    send(8'h34);
    check("good_core_rst", int'(core_rst), 0);
    check("good_done", int'(done), 1);
    check("good_err", int'(err), 0);

    // Back-pressure while running.
    in_data = 8'hA5; in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      check("bp_in_ready", int'(in_ready), 0);
      check("bp_done", int'(done), 1);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    check("bp_core_rst", int'(core_rst), 0);

    // Bad checksum, then recovery from ERROR.
    do_reset();
    expect_write(0, 'h123);
    send(8'hA5); send(8'h01); send(8'h01); send(8'h23); send(8'h00);
    check("badcs_err", int'(err), 1);
    check("badcs_core_rst", int'(core_rst), 1);
    check("badcs_done", int'(done), 0);
    send(8'h55);
    check("err_discard_err", int'(err), 1);
    send(8'hA5);
    check("resync_err_clear", int'(err), 0);
    expect_write(0, 'h005);
    send(8'h01); send(8'h00); send(8'h05); send(8'h06);
    check("recover_done", int'(done), 1);
    check("recover_err", int'(err), 0);

    // Zero count after ignored junk.
    do_reset();
    send(8'h11); send(8'h22);
    check("junk_err", int'(err), 0);
    send(8'hA5); send(8'h00);
    check("zero_count_err", int'(err), 1);
    check("zero_count_core_rst", int'(core_rst), 1);

    // COUNT above 2^ADDR_W rejected; then a full-depth load with wrap.
    send(8'hA5); send(8'h05);
    check("over_count_err", int'(err), 1);
    expect_write(0, 'h101);
    expect_write(1, 'h002);
    expect_write(2, 'h003);
    expect_write(3, 'hF04);
    send(8'hA5); send(8'h04);
    send(8'hF1); send(8'h01); send(8'h00); send(8'h02);
    send(8'h00); send(8'h03); send(8'h0F); send(8'h04);
    send(8'h0E);
    check("full_depth_done", int'(done), 1);
    check("full_depth_err", int'(err), 0);

    // Inter-byte timeout.
    do_reset();
    send(8'hA5); send(8'h03); send(8'h01);
    repeat (TIMEOUT - 1) @(posedge clk);
    #1;
    check("timeout_err_before", int'(err), 0);
    @(posedge clk); #1;
    check("timeout_err", int'(err), 1);
    check("timeout_core_rst", int'(core_rst), 1);

    // Reset in the middle of a frame.
    do_reset();
    expect_write(0, 'h123);
    send(8'hA5); send(8'h02); send(8'h01); send(8'h23);
    rst = 1'b1; in_data = 8'hA5; in_valid = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; in_valid = 1'b0;
    check_reset_vals("midrst");
    expect_write(0, 'h007);
    send(8'hA5); send(8'h01); send(8'h00); send(8'h07); send(8'h08);
    check("midrst_done", int'(done), 1);
    check("midrst_core_rst", int'(core_rst), 0);

    repeat (4) @(posedge clk);
    #1;
    check("writes_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
